// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, FSM states, token lookup.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SETTLE,
        ST_LOCKED
    } state_e;

    // Returns {is_token, ctrl[1:0]}
    function automatic logic [2:0] token_ctrl(input logic [9:0] w);
        case (w)
            CTRL_TOKEN_00: return 3'b100;
            CTRL_TOKEN_01: return 3'b101;
            CTRL_TOKEN_10: return 3'b110;
            CTRL_TOKEN_11: return 3'b111;
            default:       return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational classify of one 10b TMDS word and 10b->8b data decode.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] w;

    always_comb begin
        {is_token, ctrl} = token_ctrl(word);
        w = word[9] ? ~word[7:0] : word[7:0];
        data = '0;
        data[0] = w[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = word[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with control-token word alignment and bitslip.
// Optional TMDS_DECODER_STATS_EN adds slip_count_out (bitslips since reset).
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_MATCH    = 16,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_SETTLE   = 8,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  tmds_in,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        ve_out,
    output logic        locked_out,
    output logic        bitslip_out
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [15:0] slip_count_out
`endif
);

    localparam int IDLE_MAX = (SEARCH_WINDOW > LOCK_TIMEOUT) ? SEARCH_WINDOW : LOCK_TIMEOUT;
    localparam int TOK_W    = $clog2(CTRL_MATCH + 1);
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam int SET_W    = $clog2(SLIP_SETTLE + 1);

    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(CTRL_MATCH - 1);
    localparam logic [IDLE_W-1:0] WIN_LAST  = IDLE_W'(SEARCH_WINDOW - 1);
    localparam logic [IDLE_W-1:0] LOST_LAST = IDLE_W'(LOCK_TIMEOUT - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);

    logic [9:0]        word_q;
    state_e            state_q, state_d;
    logic [TOK_W-1:0]  tok_q, tok_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [7:0]        data_d;
    logic [1:0]        ctrl_d;
    logic              ve_d, lock_d, slip_d;

    logic              is_token;
    logic [1:0]        ctrl;
    logic [7:0]        dec;

    tmds_word_decode u_dec (
        .word     (word_q),
        .is_token (is_token),
        .ctrl     (ctrl),
        .data     (dec)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) word_q <= '0;
        else        word_q <= tmds_in;
    end

    always_comb begin
        state_d  = state_q;
        tok_d    = tok_q;
        idle_d   = idle_q;
        settle_d = settle_q;
        data_d   = data_out;
        ctrl_d   = control_out;
        ve_d     = 1'b0;
        lock_d   = 1'b0;
        slip_d   = 1'b0;
        unique case (state_q)
            ST_SEARCH: begin
                data_d = '0;
                ctrl_d = '0;
                if (is_token) begin
                    idle_d = '0;
                    if (tok_q == TOK_LAST) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                        ctrl_d  = ctrl;
                        tok_d   = '0;
                    end else begin
                        tok_d = tok_q + 1'b1;
                    end
                end else begin
                    tok_d = '0;
                    if (idle_q == WIN_LAST) begin
                        state_d  = ST_SETTLE;
                        slip_d   = 1'b1;
                        idle_d   = '0;
                        settle_d = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                data_d = '0;
                ctrl_d = '0;
                if (settle_q == SET_LAST) begin
                    state_d  = ST_SEARCH;
                    settle_d = '0;
                    tok_d    = '0;
                    idle_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                lock_d = 1'b1;
                if (is_token) begin
                    ctrl_d = ctrl;
                    idle_d = '0;
                end else if (idle_q == LOST_LAST) begin
                    // Alignment presumed lost: re-hunt before any slip
                    state_d = ST_SEARCH;
                    lock_d  = 1'b0;
                    data_d  = '0;
                    ctrl_d  = '0;
                    idle_d  = '0;
                    tok_d   = '0;
                end else begin
                    data_d = dec;
                    ve_d   = 1'b1;
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_SEARCH;
            tok_q       <= '0;
            idle_q      <= '0;
            settle_q    <= '0;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
            locked_out  <= 1'b0;
            bitslip_out <= 1'b0;
        end else begin
            state_q     <= state_d;
            tok_q       <= tok_d;
            idle_q      <= idle_d;
            settle_q    <= settle_d;
            data_out    <= data_d;
            control_out <= ctrl_d;
            ve_out      <= ve_d;
            locked_out  <= lock_d;
            bitslip_out <= slip_d;
        end
    end

`ifdef TMDS_DECODER_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in)
            slip_count_out <= '0;
        else if (slip_d && slip_count_out != 16'hFFFF)
            slip_count_out <= slip_count_out + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: random and directed streams vs a
// behavioural model, plus a bitslip-reacting deserializer model.
module tb_tmds_decoder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [9:0]  tmds_in = '0;
    logic [7:0]  data_out;
    logic [1:0]  control_out;
    logic        ve_out;
    logic        locked_out;
    logic        bitslip_out;
`ifdef TMDS_DECODER_STATS_EN
    logic [15:0] slip_count_out;
`endif

    tmds_decoder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .tmds_in     (tmds_in),
        .data_out    (data_out),
        .control_out (control_out),
        .ve_out      (ve_out),
        .locked_out  (locked_out),
        .bitslip_out (bitslip_out)
`ifdef TMDS_DECODER_STATS_EN
        ,
        .slip_count_out (slip_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       lk;
        logic       ve;
        logic       sl;
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_slip = 0;
    int last_slip = -1;

    // Behavioural reference state
    bit         m_lock;
    int         m_settle, m_run, m_idle;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;

    function automatic bit tok_of(input logic [9:0] w, output logic [1:0] c);
        c = 2'b00;
        if (w == 10'h354) begin c = 2'b00; return 1; end
        if (w == 10'h0AB) begin c = 2'b01; return 1; end
        if (w == 10'h154) begin c = 2'b10; return 1; end
        if (w == 10'h2AB) begin c = 2'b11; return 1; end
        return 0;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] w, d;
        w = q[9] ? ~q[7:0] : q[7:0];
        d[0] = w[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        logic [1:0] c;
        do w = 10'($urandom_range(0, 1023)); while (tok_of(w, c));
        return w;
    endfunction

    task automatic model_step(input logic [9:0] w);
        exp_t e;
        logic [1:0] c;
        bit t;
        t = tok_of(w, c);
        e = '{due: cyc + 2, lk: 0, ve: 0, sl: 0, d: 8'h00, c: 2'b00};
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) begin m_run = 0; m_idle = 0; end
        end else if (!m_lock) begin
            if (t) begin
                m_run++;
                m_idle = 0;
                if (m_run == 16) begin
                    m_lock = 1; m_run = 0; m_ctrl = c; m_data = 8'h00;
                    e.lk = 1; e.c = c;
                end
            end else begin
                m_run = 0;
                m_idle++;
                if (m_idle == 2048) begin
                    e.sl = 1; m_settle = 8; m_idle = 0;
                end
            end
        end else begin
            if (t) begin
                m_ctrl = c; m_idle = 0;
                e.lk = 1; e.c = c; e.d = m_data;
            end else begin
                m_idle++;
                if (m_idle == 4096) begin
                    m_lock = 0; m_idle = 0; m_run = 0;
                    m_ctrl = 2'b00; m_data = 8'h00;
                end else begin
                    m_data = ref_decode(w);
                    e.lk = 1; e.ve = 1; e.d = m_data; e.c = m_ctrl;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic [9:0] w);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        tmds_in = w;
        model_step(w);
    endtask

    task automatic do_reset();
        exp_t z;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        tmds_in = '0;
        sb.delete();
        m_lock = 0; m_settle = 0; m_run = 0; m_idle = 0;
        m_data = 8'h00; m_ctrl = 2'b00;
        last_slip = -1;
        z = '{due: cyc + 1, lk: 0, ve: 0, sl: 0, d: 8'h00, c: 2'b00};
        sb.push_back(z);
        // stage-1 register is cleared to 0, which stage 2 sees as data
        model_step(10'h000);
    endtask

    task automatic tokens(input int n, input logic [9:0] t);
        for (int i = 0; i < n; i++) drive(t);
    endtask

    always @(negedge clk_in) begin : mon
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_chk++;
            if ({locked_out, ve_out, bitslip_out, data_out, control_out} !==
                {e.lk, e.ve, e.sl, e.d, e.c}) begin
                n_fail++;
                $display("FAIL out@%0d got lk=%b ve=%b sl=%b d=%h c=%b want lk=%b ve=%b sl=%b d=%h c=%b",
                         cyc, locked_out, ve_out, bitslip_out, data_out, control_out,
                         e.lk, e.ve, e.sl, e.d, e.c);
            end
        end
        if (bitslip_out === 1'b1) begin
            n_slip++;
            if (last_slip >= 0) begin
                n_chk++;
                if (cyc - last_slip < 2056) begin
                    n_fail++;
                    $display("FAIL slip_spacing got %0d want >=2056", cyc - last_slip);
                end
            end
            last_slip = cyc;
        end
    end

    initial begin
        int rot, s0, got_lock;
        logic [19:0] tt;

        do_reset();
`ifdef TMDS_DECODER_STATS_EN
        drive(rand_data());
        n_chk++;
        if (slip_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL slip_count_reset got %0d want 0", slip_count_out);
        end
`endif
        // Aligned lock and first data word
        tokens(20, 10'h354);
        drive(10'h100);
        for (int i = 0; i < 4; i++) drive(rand_data());

        // Control tokens after lock, held through data
        drive(10'h0AB);
        for (int i = 0; i < 3; i++) drive(rand_data());
        drive(10'h154);
        for (int i = 0; i < 3; i++) drive(rand_data());
        drive(10'h2AB);
        for (int i = 0; i < 3; i++) drive(rand_data());

        // Random mix while locked
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: drive(10'h354);
                    1: drive(10'h0AB);
                    2: drive(10'h154);
                    default: drive(10'h2AB);
                endcase
            end else begin
                drive(10'($urandom_range(0, 1023)));
            end
        end

        // Loss of lock on a long data run
        drive(10'h2AB);
        for (int i = 0; i < 4100; i++) drive(rand_data());

        // Reset mid-lock, then relock needs fresh tokens
        tokens(16, 10'h154);
        for (int i = 0; i < 3; i++) drive(rand_data());
        do_reset();
        tokens(15, 10'h354);
        drive(10'h100);
        tokens(15, 10'h0AB);
        tokens(1, 10'h0AB);
        for (int i = 0; i < 4; i++) drive(rand_data());

        // Misaligned stream through a bitslip-reacting deserializer
        do_reset();
        s0 = n_slip;
        rot = 3;
        tt = {10'h354, 10'h354};
        got_lock = 0;
        for (int i = 0; i < 9000 && got_lock == 0; i++) begin
            @(posedge clk_in);
            #1;
            if (bitslip_out === 1'b1) rot = (rot == 0) ? 9 : rot - 1;
            if (locked_out === 1'b1) got_lock = 1;
            rst_in = 1'b0;
            tmds_in = tt[rot +: 10];
            model_step(tt[rot +: 10]);
        end
        n_chk++;
        if (got_lock == 0) begin
            n_fail++;
            $display("FAIL misaligned_lock got 0 want 1 within 9000 cycles");
        end
        n_chk++;
        if (n_slip - s0 != 3) begin
            n_fail++;
            $display("FAIL misaligned_slips got %0d want 3", n_slip - s0);
        end
`ifdef TMDS_DECODER_STATS_EN
        n_chk++;
        if (slip_count_out !== 16'd3) begin
            n_fail++;
            $display("FAIL slip_count got %0d want 3", slip_count_out);
        end
`endif
        drive(10'h100);
        for (int i = 0; i < 3; i++) drive(rand_data());

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_in);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
